set_job_dispatcher: RTL
=======================

// Module: set_job_dispatcher
// PURPOSE
//  Upstream feeder for the SET intersection counter. Buffers (central, radius) jobs in a small FIFO
//  and issues them to SET one at a time: pulses en, holds central/radius stable until SET's valid,
//  captures candidate and returns it on a ready/valid result port. A watchdog aborts hung jobs.
// PARAMETERS
//  DEPTH    4   job FIFO entries; power of 2, >=2
//  TIMEOUT  15  max cycles in WAIT without set_valid before abort (1..255)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  job_valid      in   1   upstream job offered
//  job_ready      out  1   FIFO can accept; accept = job_valid & job_ready at posedge
//  job_central    in   16  {x1,y1,x2,y2}, 4b each
//  job_radius     in   8   {r1,r2}, 4b each
//  set_en         out  1   to SET.en
//  set_central    out  16  to SET.central
//  set_radius     out  8   to SET.radius
//  set_busy       in   1   from SET.busy (monitor only)
//  set_valid      in   1   from SET.valid
//  set_candidate  in   8   from SET.candidate
//  res_valid      out  1   result held until res_ready
//  res_ready      in   1   downstream accepts result
//  res_count      out  8   candidate count; 8'hFF on timeout
//  res_seq        out  8   job sequence number, wraps 255->0
//  timeout_err    out  1   sticky; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except job_ready=1; FIFO empty; seq=0; FSM=IDLE. Reset mid-job abandons
//    the job with no result; set_en falls immediately.
//  - FIFO: job_ready = !full (registered count); no push when full, even with a same-cycle pop.
//    Push and pop in the same cycle when not full/empty: count unchanged. Pointers wrap mod DEPTH.
//  - FSM IDLE: FIFO non-empty & !res_valid -> ISSUE; set_central/set_radius load FIFO head.
//  - ISSUE (1 cycle): set_en=1. -> WAIT; watchdog cleared.
//  - WAIT: set_en=0; set_central/set_radius held constant (SET reads radius combinationally for
//    its 3-stage multipliers). set_valid=1 -> capture set_candidate into res_count, res_seq=seq,
//    seq++, pop FIFO, -> RESULT. Watchdog reaches TIMEOUT -> res_count=8'hFF, timeout_err=1, pop,
//    seq++, -> RESULT. If set_valid and timeout occur in the same cycle, set_valid wins.
//  - RESULT: res_valid=1, res_count/res_seq stable until res_ready sampled high -> IDLE;
//    res_valid drops next cycle.
//  - set_valid outside WAIT is ignored. set_busy is not used for control.
//  - Latency: job accepted at edge k into an empty, idle block -> set_en high in cycle k+1..k+2;
//    res_valid high the cycle after set_valid is sampled.
//  - Outside ISSUE/WAIT, set_central/set_radius keep their last value (no toggling, low power).
//  - central==16'h0000 never makes SET busy; such jobs exit through the timeout path.
// CONFIGURATION
//  SET_DISP_LAT_STATS_EN defined: adds output lat_max[7:0], the largest observed ISSUE-to-set_valid
//    cycle count (saturating at 255; timed-out jobs excluded; reset to 0).
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING (bench uses real SET or a cycle-equivalent model)
//  1 central=16'h4444 radius=8'h11, res_ready=1 -> one set_en pulse, res_count=5, res_seq=0.
//  2 push 5 jobs back-to-back with DEPTH=4 and res_ready=0 -> job_ready=0 after 4th accept, 5th
//    held; release res_ready -> 5 results in order, res_seq 0..4.
//  3 central=16'h0000 -> after 15 WAIT cycles res_count=8'hFF, timeout_err=1; next good job
//    completes normally.
//  4 assert rst_n low during WAIT -> set_en=0, res_valid=0, job_ready=1, seq=0 immediately.
//  5 inject stray set_valid during IDLE -> no result, FSM stays IDLE.
//  6 with SET_DISP_LAT_STATS_EN: run job of test 1 -> lat_max equals measured ISSUE-to-valid count.

Source files
------------

// File: rtl/set_job_dispatcher.sv
// Job FIFO and one-at-a-time issuer in front of the SET intersection counter, with a watchdog.
// Optional build macro SET_DISP_LAT_STATS_EN adds lat_max (largest ISSUE-to-set_valid latency).
module set_job_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_central,
  input  logic [7:0]  job_radius,
  output logic        set_en,
  output logic [15:0] set_central,
  output logic [7:0]  set_radius,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_count,
  output logic [7:0]  res_seq,
`ifdef SET_DISP_LAT_STATS_EN
  output logic [7:0]  lat_max,
`endif
  output logic        timeout_err
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [7:0]  WdLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResult} state_e;

  state_e state_q, state_d;

  // SET busy is informational only; control relies on set_valid and the watchdog.
  logic unused_set_busy;
  assign unused_set_busy = set_busy;

  // ---------------------------------------------------------------------------
  // Job FIFO
  // ---------------------------------------------------------------------------
  logic [23:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [23:0]     head;

  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign job_ready  = ~fifo_full;
  assign push       = job_valid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {job_central, job_radius};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [7:0] wd_q, wd_d;
  logic       wd_hit;
  logic       load_head;
  logic       wait_ok;
  logic       wait_to;

  assign wd_hit = (wd_q == WdLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (set_valid || wd_hit) begin
          state_d = StResult;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    set_en    = 1'b0;
    res_valid = 1'b0;
    load_head = 1'b0;
    wait_ok   = 1'b0;
    wait_to   = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_head = ~fifo_empty;
      end
      StIssue: begin
        set_en = 1'b1;
      end
      StWait: begin
        // A result arriving on the watchdog's last cycle still counts as good.
        wait_ok = set_valid;
        wait_to = ~set_valid & wd_hit;
      end
      StResult: begin
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign pop = wait_ok | wait_to;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [15:0] central_q, central_d;
  logic [7:0]  radius_q, radius_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  res_count_q, res_count_d;
  logic [7:0]  res_seq_q, res_seq_d;
  logic        terr_q, terr_d;

  always_comb begin
    central_d   = central_q;
    radius_d    = radius_q;
    wd_d        = wd_q;
    seq_d       = seq_q;
    res_count_d = res_count_q;
    res_seq_d   = res_seq_q;
    terr_d      = terr_q;
    if (load_head) begin
      central_d = head[23:8];
      radius_d  = head[7:0];
    end
    if (state_q == StIssue) begin
      wd_d = '0;
    end else if (state_q == StWait) begin
      wd_d = wd_q + 8'd1;
    end
    if (wait_ok) begin
      res_count_d = set_candidate;
      res_seq_d   = seq_q;
      seq_d       = seq_q + 8'd1;
    end else if (wait_to) begin
      res_count_d = 8'hFF;
      res_seq_d   = seq_q;
      seq_d       = seq_q + 8'd1;
      terr_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      central_q   <= '0;
      radius_q    <= '0;
      wd_q        <= '0;
      seq_q       <= '0;
      res_count_q <= '0;
      res_seq_q   <= '0;
      terr_q      <= 1'b0;
    end else begin
      central_q   <= central_d;
      radius_q    <= radius_d;
      wd_q        <= wd_d;
      seq_q       <= seq_d;
      res_count_q <= res_count_d;
      res_seq_q   <= res_seq_d;
      terr_q      <= terr_d;
    end
  end

  assign set_central = central_q;
  assign set_radius  = radius_q;
  assign res_count   = res_count_q;
  assign res_seq     = res_seq_q;
  assign timeout_err = terr_q;

`ifdef SET_DISP_LAT_STATS_EN
  // Latency counts the ISSUE cycle as 0, so the first WAIT cycle is 1.
  logic [7:0] lat_max_q, lat_max_d;
  logic [8:0] lat_obs;

  assign lat_obs = {1'b0, wd_q} + 9'd1;

  always_comb begin
    lat_max_d = lat_max_q;
    if (wait_ok && (lat_obs > {1'b0, lat_max_q})) begin
      lat_max_d = lat_obs[8] ? 8'hFF : lat_obs[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_max_q <= '0;
    end else begin
      lat_max_q <= lat_max_d;
    end
  end

  assign lat_max = lat_max_q;
`endif

endmodule
